// File: rtl/alu_share_arbiter_pkg.sv
// Package for the shared-ALU arbiter slice.
// Holds the ALU32Bit opcode values the arbiter cares about, the default
// control/data widths and the arbiter FSM state type.
package alu_share_arbiter_pkg;

    localparam int unsigned ALU_CTRL_W = 5;
    localparam int unsigned ALU_DATA_W = 32;

    // ALU32Bit ALUControl codes (only ALU_MUL is ever decoded by the arbiter)
    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_MUL  = 5'b00011;
    localparam logic [4:0] ALU_BEQ  = 5'b01100;
    localparam logic [4:0] ALU_BLTZ = 5'b10010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Picks the first asserted Valid bit at or after Ptr, wrapping modulo NUM_REQ.
// Ports:
//   Valid    in  NUM_REQ  request vector
//   Ptr      in  ID_W     index with highest priority
//   Grant    out NUM_REQ  one-hot grant (all zero when nothing valid)
//   GrantIdx out ID_W     index of the granted bit
//   Any      out 1        some Valid bit is set
module alu_share_arbiter_rr_picker #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] Valid,
    input  logic [ID_W-1:0]    Ptr,
    output logic [NUM_REQ-1:0] Grant,
    output logic [ID_W-1:0]    GrantIdx,
    output logic               Any
);

    logic [ID_W-1:0] w_idx;

    // Walk the candidate index from Ptr forward; the first valid match wins.
    always_comb begin
        Grant    = '0;
        GrantIdx = '0;
        Any      = 1'b0;
        w_idx    = Ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!Any && Valid[i] && (ID_W'(i) == w_idx)) begin
                    Grant[i] = 1'b1;
                    GrantIdx = ID_W'(i);
                    Any      = 1'b1;
                end
            end
            w_idx = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU32Bit among NUM_REQ requesters with round-robin arbitration.
// A granted op is latched, drives the ALU from registers during EXEC, the
// ALU result is captured and returned with the requester ID in RESP.
// Optional feature macro: ALU_MUL_STALL_EN (multiply ops stay MUL_LAT cycles
// in EXEC; without it every op takes one EXEC cycle).
// Ports:
//   Clk, Reset                 clock (rising), async active-low reset
//   ReqValid/ReqReady          per-requester handshake (ReqReady one-hot)
//   ReqCtrl/ReqA/ReqB          packed per-requester op, requester i at slice i
//   AluControl/AluA/AluB       registered op to ALU32Bit
//   AluResult/AluZero          ALU32Bit outputs
//   RespValid/RespReady        response handshake
//   RespId/RespResult/RespZero response payload
//   Busy                       high whenever not IDLE
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned CTRL_W  = ALU_CTRL_W,
    parameter int unsigned DATA_W  = ALU_DATA_W,
    parameter int unsigned ID_W    = 3,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         ReqValid,
    output logic [NUM_REQ-1:0]         ReqReady,
    input  logic [NUM_REQ*CTRL_W-1:0]  ReqCtrl,
    input  logic [NUM_REQ*DATA_W-1:0]  ReqA,
    input  logic [NUM_REQ*DATA_W-1:0]  ReqB,
    output logic [CTRL_W-1:0]          AluControl,
    output logic [DATA_W-1:0]          AluA,
    output logic [DATA_W-1:0]          AluB,
    input  logic [DATA_W-1:0]          AluResult,
    input  logic                       AluZero,
    output logic                       RespValid,
    input  logic                       RespReady,
    output logic [ID_W-1:0]            RespId,
    output logic [DATA_W-1:0]          RespResult,
    output logic                       RespZero,
    output logic                       Busy
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || MUL_LAT < 1) begin : g_bad_params
        $error("alu_share_arbiter: invalid parameter set");
    end

    arb_state_t          r_state, w_state_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [DATA_W-1:0]   r_a, r_b, r_result;
    logic [ID_W-1:0]     r_id;
    logic                r_zero;

    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_grant_idx;
    logic                w_any;
    logic                w_accept;
    logic                w_exec_last;
    logic [CTRL_W-1:0]   w_sel_ctrl;
    logic [DATA_W-1:0]   w_sel_a, w_sel_b;

    alu_share_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .Valid    (ReqValid),
        .Ptr      (r_ptr),
        .Grant    (w_grant),
        .GrantIdx (w_grant_idx),
        .Any      (w_any)
    );

    assign w_accept = (r_state == S_IDLE) && w_any;

    // One-hot grant doubles as the operand mux select.
    always_comb begin
        w_sel_ctrl = '0;
        w_sel_a    = '0;
        w_sel_b    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_ctrl = ReqCtrl[i*CTRL_W +: CTRL_W];
                w_sel_a    = ReqA[i*DATA_W +: DATA_W];
                w_sel_b    = ReqB[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef ALU_MUL_STALL_EN
    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    logic [CNT_W-1:0] r_mul_cnt;

    // Counter holds the remaining extra EXEC cycles; zero marks the last one.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_mul_cnt <= '0;
        end else if (w_accept) begin
            r_mul_cnt <= (w_sel_ctrl == CTRL_W'(ALU_MUL)) ? CNT_W'(MUL_LAT - 1) : '0;
        end else if (r_state == S_EXEC && r_mul_cnt != '0) begin
            r_mul_cnt <= r_mul_cnt - 1'b1;
        end
    end

    assign w_exec_last = (r_mul_cnt == '0);
`else
    assign w_exec_last = 1'b1;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any)       w_state_nxt = S_EXEC;
            S_EXEC:  if (w_exec_last) w_state_nxt = S_RESP;
            S_RESP:  if (RespReady)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_ptr    <= '0;
            r_ctrl   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_id     <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ctrl <= w_sel_ctrl;
                r_a    <= w_sel_a;
                r_b    <= w_sel_b;
                r_id   <= w_grant_idx;
            end
            if (r_state == S_EXEC && w_exec_last) begin
                r_result <= AluResult;
                r_zero   <= AluZero;
            end
            // Priority moves just past the requester that was served.
            if (r_state == S_RESP && RespReady) begin
                r_ptr <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);
            end
        end
    end

    assign ReqReady   = (r_state == S_IDLE) ? w_grant : '0;
    assign AluControl = r_ctrl;
    assign AluA       = r_a;
    assign AluB       = r_b;
    assign RespValid  = (r_state == S_RESP);
    assign RespId     = r_id;
    assign RespResult = r_result;
    assign RespZero   = r_zero;
    assign Busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    logic        Clk;
    logic        Reset;
    logic [1:0]  ReqValid;
    logic [1:0]  ReqReady;
    logic [9:0]  ReqCtrl;
    logic [63:0] ReqA;
    logic [63:0] ReqB;
    logic [4:0]  AluControl;
    logic [31:0] AluA;
    logic [31:0] AluB;
    logic [31:0] AluResult;
    logic        AluZero;
    logic        RespValid;
    logic        RespReady;
    logic [2:0]  RespId;
    logic [31:0] RespResult;
    logic        RespZero;
    logic        Busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side ALU stand-in, with an override to drive arbitrary values.
    logic        tb_ovr;
    logic [31:0] tb_ovr_res;
    logic        tb_ovr_zero;
    logic [31:0] model_res;

    always_comb begin
        case (AluControl)
            5'b00001: model_res = AluA + AluB;
            5'b00011: model_res = AluA * AluB;
            5'b01100: model_res = AluA - AluB;
            default:  model_res = AluA ^ AluB;
        endcase
        AluResult = tb_ovr ? tb_ovr_res  : model_res;
        AluZero   = tb_ovr ? tb_ovr_zero : (model_res == 32'd0);
    end

    alu_share_arbiter #(
        .NUM_REQ (2),
        .CTRL_W  (5),
        .DATA_W  (32),
        .ID_W    (3),
        .MUL_LAT (3)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ReqValid   (ReqValid),
        .ReqReady   (ReqReady),
        .ReqCtrl    (ReqCtrl),
        .ReqA       (ReqA),
        .ReqB       (ReqB),
        .AluControl (AluControl),
        .AluA       (AluA),
        .AluB       (AluB),
        .AluResult  (AluResult),
        .AluZero    (AluZero),
        .RespValid  (RespValid),
        .RespReady  (RespReady),
        .RespId     (RespId),
        .RespResult (RespResult),
        .RespZero   (RespZero),
        .Busy       (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        ReqCtrl[i*5 +: 5]  = c;
        ReqA[i*32 +: 32]   = a;
        ReqB[i*32 +: 32]   = b;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_id;
        int cyc;
        int seen;
        bit done;
        int exp_lat;

        Reset = 1'b0; ReqValid = '0; ReqCtrl = '0; ReqA = '0; ReqB = '0;
        RespReady = 1'b0; tb_ovr = 1'b0; tb_ovr_res = '0; tb_ovr_zero = 1'b0;
        tick(); tick();
        #2 Reset = 1'b1;
        tick();

        // Reset state
        check("rst_busy",     {31'd0, Busy},      32'd0);
        check("rst_respv",    {31'd0, RespValid}, 32'd0);
        check("rst_reqready", {30'd0, ReqReady},  32'd0);
        check("rst_aluctl",   {27'd0, AluControl}, 32'd0);
        check("rst_alua",     AluA,               32'd0);

        // 1: single op, 5 + 7
        set_req(0, 5'b00001, 32'd5, 32'd7);
        ReqValid = 2'b01;
        #1;
        check("t1_ready", {30'd0, ReqReady}, 32'd1);
        tick();
        ReqValid = '0;
        check("t1_exec_busy",  {31'd0, Busy},      32'd1);
        check("t1_exec_rdy",   {30'd0, ReqReady},  32'd0);
        check("t1_exec_respv", {31'd0, RespValid}, 32'd0);
        check("t1_alu_a",      AluA,               32'd5);
        check("t1_alu_b",      AluB,               32'd7);
        check("t1_alu_ctl",    {27'd0, AluControl}, 32'd1);
        tick();
        check("t1_respv",  {31'd0, RespValid}, 32'd1);
        check("t1_id",     {29'd0, RespId},    32'd0);
        check("t1_result", RespResult,         32'd12);
        check("t1_zero",   {31'd0, RespZero},  32'd0);
        RespReady = 1'b1;
        tick();
        check("t1_idle", {31'd0, Busy}, 32'd0);

        // 2: contention, pointer now at 1 so grants go 1,0,1,0
        set_req(0, 5'b00001, 32'd1,  32'd2);
        set_req(1, 5'b00001, 32'd10, 32'd20);
        ReqValid = 2'b11;
        exp_id = 1;
        for (int n = 0; n < 4; n++) begin
            #1;
            check("t2_grant", {30'd0, ReqReady}, (exp_id == 1) ? 32'd2 : 32'd1);
            tick();
            tick();
            check("t2_id",     {29'd0, RespId}, exp_id);
            check("t2_result", RespResult, (exp_id == 1) ? 32'd30 : 32'd3);
            tick();
            exp_id = 1 - exp_id;
        end
        ReqValid = '0;

        // 3: backpressure on requester 1, result 101
        RespReady = 1'b0;
        set_req(1, 5'b00001, 32'd100, 32'd1);
        ReqValid = 2'b10;
        tick();
        ReqValid = '0;
        tick();
        ReqValid = 2'b11;
        for (int n = 0; n < 5; n++) begin
            check("t3_respv",  {31'd0, RespValid}, 32'd1);
            check("t3_id",     {29'd0, RespId},    32'd1);
            check("t3_result", RespResult,         32'd101);
            check("t3_ready",  {30'd0, ReqReady},  32'd0);
            tick();
        end
        RespReady = 1'b1;
        tick();
        // Served id 1 = NUM_REQ-1, so the pointer wraps to 0
        check("t3_wrap_grant", {30'd0, ReqReady}, 32'd1);
        ReqValid = '0;
        #1;

        // 4: beq compare, captured value is whatever the ALU drives
        set_req(0, 5'b01100, 32'd9, 32'd9);
        tb_ovr = 1'b1; tb_ovr_res = 32'h1234_5678; tb_ovr_zero = 1'b1;
        RespReady = 1'b0;
        ReqValid = 2'b01;
        tick();
        ReqValid = '0;
        check("t4_alu_ctl", {27'd0, AluControl}, 32'h0C);
        tick();
        check("t4_result", RespResult,        32'h1234_5678);
        check("t4_zero",   {31'd0, RespZero}, 32'd1);
        tb_ovr = 1'b0;
        RespReady = 1'b1;
        tick();

        // 5: reset while in EXEC (op from requester 1, pointer at 1)
        set_req(1, 5'b00001, 32'd40, 32'd2);
        ReqValid = 2'b10;
        tick();
        ReqValid = '0;
        check("t5_busy_pre", {31'd0, Busy}, 32'd1);
        #2 Reset = 1'b0;
        #1;
        check("t5_rst_busy",  {31'd0, Busy},       32'd0);
        check("t5_rst_alua",  AluA,                32'd0);
        check("t5_rst_ctl",   {27'd0, AluControl}, 32'd0);
        check("t5_rst_respv", {31'd0, RespValid},  32'd0);
        tick(); tick();
        #2 Reset = 1'b1;
        seen = 0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (RespValid) seen++;
        end
        check("t5_no_resp", seen, 32'd0);
        set_req(0, 5'b00001, 32'd6, 32'd6);
        ReqValid = 2'b11;
        #1;
        check("t5_ptr0_grant", {30'd0, ReqReady}, 32'd1);
        tick();
        ReqValid = '0;
        tick();
        check("t5_id",     {29'd0, RespId}, 32'd0);
        check("t5_result", RespResult,      32'd12);
        tick();

        // 6: multiply -3 * 4
`ifdef ALU_MUL_STALL_EN
        exp_lat = 4;
`else
        exp_lat = 2;
`endif
        RespReady = 1'b0;
        set_req(0, 5'b00011, 32'hFFFF_FFFD, 32'd4);
        ReqValid = 2'b01;
        #1;
        check("t6_ready", {30'd0, ReqReady}, 32'd1);
        cyc = 0;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            tick();
            if (k == 0) ReqValid = '0;
            cyc++;
            if (RespValid) done = 1'b1;
        end
        check("t6_got_resp", {31'd0, done}, 32'd1);
        check("t6_latency",  cyc,           exp_lat);
        check("t6_result",   RespResult,    32'hFFFF_FFF4);
        RespReady = 1'b1;
        tick();
        check("t6_idle", {31'd0, Busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
